// File: rtl/hazard_scoreboard_if.sv
// Issue/read-port bundle between the issue stage (master) and the hazard scoreboard (slave).
// Handshake: an instruction is accepted on a rising clk edge when issue_valid=1, stall=0, flush=0; stall is the ready-low backpressure.
interface hazard_scoreboard_if #(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    parameter int NPORT  = 2
);
    localparam int SELW = $clog2(DEPTH + 1);

    logic                    issue_valid;
    logic                    issue_wren;
    logic [REG_AW-1:0]       issue_wraddr;
    logic                    issue_isload;
    logic                    flush;
    logic [NPORT-1:0]        rdreq;
    logic [NPORT*REG_AW-1:0] rdaddr;
    logic                    stall;
    logic [NPORT*SELW-1:0]   fwdsel;
    logic [SELW-1:0]         inflight;
    logic                    busy;

    modport master (
        output issue_valid, issue_wren, issue_wraddr, issue_isload, flush, rdreq, rdaddr,
        input  stall, fwdsel, inflight, busy
    );

    modport slave (
        input  issue_valid, issue_wren, issue_wraddr, issue_isload, flush, rdreq, rdaddr,
        output stall, fwdsel, inflight, busy
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight register writers per pipeline stage and resolves forwarding / load-use stalls.
// Optional perf counters (stall_count, fwd_count) are built when HAZARD_SCOREBOARD_PERF_EN is defined.
module hazard_scoreboard #(
    parameter int REG_AW     = 5,
    parameter int DEPTH      = 3,
    parameter int NPORT      = 2,
    parameter int LOAD_STAGE = 2
) (
    input  logic               clk,
    input  logic               rst,
    hazard_scoreboard_if.slave sb
`ifdef HAZARD_SCOREBOARD_PERF_EN
    ,
    output logic [31:0]        stall_count,
    output logic [31:0]        fwd_count
`endif
);
    localparam int SELW = $clog2(DEPTH + 1);

    logic [DEPTH:1]    ent_valid;
    logic [DEPTH:1]    ent_wren;
    logic [DEPTH:1]    ent_isload;
    logic [REG_AW-1:0] ent_addr [1:DEPTH];

    logic [NPORT-1:0]      port_hz;
    logic [NPORT-1:0]      found_c;
    logic [NPORT*SELW-1:0] sel_c;
    logic                  stall_c;
    logic                  accept_c;
    logic [SELW-1:0]       count_c;

    // Scan from stage 1 upward so the youngest writer claims the port first.
    always_comb begin
        port_hz = '0;
        found_c = '0;
        sel_c   = '0;
        for (int p = 0; p < NPORT; p++) begin
            for (int k = 1; k <= DEPTH; k++) begin
                if (!found_c[p] && sb.rdreq[p] &&
                    (sb.rdaddr[p*REG_AW +: REG_AW] != '0) &&
                    ent_valid[k] && ent_wren[k] &&
                    (ent_addr[k] == sb.rdaddr[p*REG_AW +: REG_AW])) begin
                    found_c[p] = 1'b1;
                    if (ent_isload[k] && (k < LOAD_STAGE)) begin
                        port_hz[p] = 1'b1;
                    end else begin
                        sel_c[p*SELW +: SELW] = SELW'(k);
                    end
                end
            end
        end
    end

    assign stall_c  = sb.issue_valid & ~sb.flush & (|port_hz);
    assign accept_c = sb.issue_valid & ~stall_c & ~sb.flush;

    always_comb begin
        count_c = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            count_c = count_c + SELW'(ent_valid[k]);
        end
    end

    assign sb.stall    = stall_c;
    assign sb.fwdsel   = sel_c;
    assign sb.inflight = count_c;
    assign sb.busy     = |ent_valid;

    // Older entries always advance; only stage 1 depends on whether the issue was accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_valid  <= '0;
            ent_wren   <= '0;
            ent_isload <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                ent_addr[k] <= '0;
            end
        end else begin
            for (int k = DEPTH; k >= 2; k--) begin
                ent_valid[k]  <= ent_valid[k-1];
                ent_wren[k]   <= ent_wren[k-1];
                ent_isload[k] <= ent_isload[k-1];
                ent_addr[k]   <= ent_addr[k-1];
            end
            ent_valid[1]  <= accept_c;
            ent_wren[1]   <= sb.issue_wren;
            ent_isload[1] <= sb.issue_isload;
            ent_addr[1]   <= sb.issue_wraddr;
        end
    end

`ifdef HAZARD_SCOREBOARD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
            fwd_count   <= '0;
        end else begin
            if (stall_c && (stall_count != '1)) begin
                stall_count <= stall_count + 32'd1;
            end
            if (accept_c && (sel_c != '0) && (fwd_count != '1)) begin
                fwd_count <= fwd_count + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed + randomized bench for hazard_scoreboard against a queue-based pipeline model.
// Perf-counter checks are compiled in only when HAZARD_SCOREBOARD_PERF_EN is defined.
module tb_hazard_scoreboard;
  localparam int REG_AW     = 5;
  localparam int DEPTH      = 3;
  localparam int NPORT      = 2;
  localparam int LOAD_STAGE = 2;
  localparam int SELW       = $clog2(DEPTH + 1);

  typedef struct packed {
    logic       v;
    logic       w;
    logic       l;
    logic [4:0] a;
  } ent_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;
  ent_t pipe[$];
  logic [31:0] exp_q[$];
  logic [31:0] m_sc;
  logic [31:0] m_fc;

  hazard_scoreboard_if #(.REG_AW(REG_AW), .DEPTH(DEPTH), .NPORT(NPORT)) bus ();

`ifdef HAZARD_SCOREBOARD_PERF_EN
  logic [31:0] stall_count;
  logic [31:0] fwd_count;
  hazard_scoreboard #(.REG_AW(REG_AW), .DEPTH(DEPTH), .NPORT(NPORT), .LOAD_STAGE(LOAD_STAGE)) dut (
    .clk(clk), .rst(rst), .sb(bus), .stall_count(stall_count), .fwd_count(fwd_count)
  );
`else
  hazard_scoreboard #(.REG_AW(REG_AW), .DEPTH(DEPTH), .NPORT(NPORT), .LOAD_STAGE(LOAD_STAGE)) dut (
    .clk(clk), .rst(rst), .sb(bus)
  );
`endif

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_count();
    int c = 0;
    foreach (pipe[i]) if (pipe[i].v) c++;
    return c;
  endfunction

  // Driver + scoreboard step: drive at negedge, compare 1ns later, then advance the model as the posedge will.
  task automatic step(input logic r, input logic iv, input logic wr, input logic [4:0] wa,
                      input logic ld, input logic fl, input logic [1:0] rq,
                      input logic [4:0] ra0, input logic [4:0] ra1);
    logic [4:0] ra [2];
    logic [SELW-1:0] e_sel [2];
    logic hz;
    logic e_stall;
    logic acc;
    ent_t ne;
    @(negedge clk);
    rst              = r;
    bus.issue_valid  = iv;
    bus.issue_wren   = wr;
    bus.issue_wraddr = wa;
    bus.issue_isload = ld;
    bus.flush        = fl;
    bus.rdreq        = rq;
    bus.rdaddr       = {ra1, ra0};
    ra[0] = ra0;
    ra[1] = ra1;
    hz = 1'b0;
    for (int p = 0; p < NPORT; p++) begin
      e_sel[p] = '0;
      if (rq[p] && ra[p] != 5'd0) begin
        for (int i = 0; i < pipe.size(); i++) begin
          if (pipe[i].v && pipe[i].w && pipe[i].a == ra[p]) begin
            if (pipe[i].l && (i + 1) < LOAD_STAGE) hz = 1'b1;
            else e_sel[p] = SELW'(i + 1);
            break;
          end
        end
      end
    end
    e_stall = iv & ~fl & hz;
    acc     = iv & ~e_stall & ~fl;
    #1;
    chk("stall", 32'(bus.stall), 32'(e_stall));
    if (!fl) begin
      for (int p = 0; p < NPORT; p++)
        chk($sformatf("fwdsel%0d", p), 32'(bus.fwdsel[p*SELW +: SELW]), 32'(e_sel[p]));
    end
    chk("inflight", 32'(bus.inflight), 32'(model_count()));
    chk("busy", 32'(bus.busy), 32'(model_count() != 0));
`ifdef HAZARD_SCOREBOARD_PERF_EN
    chk("stall_count", stall_count, m_sc);
    chk("fwd_count", fwd_count, m_fc);
`endif
    if (r) begin
      foreach (pipe[i]) pipe[i] = '0;
      m_sc = 0;
      m_fc = 0;
    end else begin
      ne = '{v: acc, w: wr, l: ld, a: wa};
      void'(pipe.pop_back());
      pipe.push_front(ne);
      if (e_stall && m_sc != 32'hFFFF_FFFF) m_sc++;
      if (acc && (e_sel[0] != 0 || e_sel[1] != 0) && m_fc != 32'hFFFF_FFFF) m_fc++;
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0);
  endtask

  task automatic issue(input logic [4:0] wa, input logic ld);
    step(1'b0, 1'b1, 1'b1, wa, ld, 1'b0, 2'b00, 5'd0, 5'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    m_sc = 0;
    m_fc = 0;
    for (int i = 0; i < DEPTH; i++) pipe.push_back('0);
    rst = 1'b1;
    bus.issue_valid = 1'b0; bus.issue_wren = 1'b0; bus.issue_wraddr = '0;
    bus.issue_isload = 1'b0; bus.flush = 1'b0; bus.rdreq = '0; bus.rdaddr = '0;

    // Reset state
    do_reset();
    do_reset();
    step(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b11, 5'd3, 5'd9);
    chk("reset_inflight", 32'(bus.inflight), 32'd0);
    chk("reset_fwdsel", 32'(bus.fwdsel), 32'd0);

    // Forward r3 through stages 1..3 then from the register file
    do_reset();
    issue(5'd3, 1'b0);
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(0);
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b01, 5'd3, 5'd0);
      chk("fwd_walk", 32'(bus.fwdsel[0 +: SELW]), exp_q.pop_front());
      chk("fwd_walk_stall", 32'(bus.stall), 32'd0);
    end

    // Load-use: one stall, then forward from stage 2
    do_reset();
    issue(5'd5, 1'b1);
    step(1'b0, 1'b1, 1'b0, 5'd6, 1'b0, 1'b0, 2'b01, 5'd5, 5'd0);
    chk("loaduse_stall", 32'(bus.stall), 32'd1);
    step(1'b0, 1'b1, 1'b0, 5'd6, 1'b0, 1'b0, 2'b01, 5'd5, 5'd0);
    chk("loaduse_release", 32'(bus.stall), 32'd0);
    chk("loaduse_fwd", 32'(bus.fwdsel[0 +: SELW]), 32'd2);
    idle();
`ifdef HAZARD_SCOREBOARD_PERF_EN
    chk("loaduse_stall_count", stall_count, 32'd1);
    chk("loaduse_fwd_count", fwd_count, 32'd1);
`endif

    // Youngest writer wins
    do_reset();
    issue(5'd4, 1'b0);
    issue(5'd4, 1'b0);
    step(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b10, 5'd0, 5'd4);
    chk("youngest_fwd", 32'(bus.fwdsel[SELW +: SELW]), 32'd1);

    // Register 0 never stalls nor forwards
    do_reset();
    issue(5'd0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 2'b11, 5'd0, 5'd0);
    chk("r0_stall", 32'(bus.stall), 32'd0);
    chk("r0_fwd", 32'(bus.fwdsel), 32'd0);

    // Flush suppresses a load-use stall; only the oldest entry retires
    do_reset();
    issue(5'd7, 1'b0);
    issue(5'd8, 1'b0);
    issue(5'd5, 1'b1);
    step(1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b1, 2'b01, 5'd5, 5'd0);
    chk("flush_stall", 32'(bus.stall), 32'd0);
    chk("flush_inflight_before", 32'(bus.inflight), 32'd3);
    step(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b01, 5'd5, 5'd0);
    chk("flush_inflight_after", 32'(bus.inflight), 32'd2);
    chk("flush_stage1_empty", 32'(bus.fwdsel[0 +: SELW]), 32'd2);

    // Reset overrides a simultaneous issue
    issue(5'd1, 1'b0);
    issue(5'd2, 1'b0);
    issue(5'd3, 1'b0);
    step(1'b1, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0);
    step(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b11, 5'd1, 5'd3);
    chk("rst_inflight", 32'(bus.inflight), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_fwdsel", 32'(bus.fwdsel), 32'd0);

    // Randomized traffic on a small register window to provoke frequent hits
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 49) == 0),
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 3) != 0),
           5'($urandom_range(0, 7)),
           1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 7) == 0),
           2'($urandom_range(0, 3)),
           5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter REG_AW, default 5, meaning register-address width.
REQ-002 SHALL have parameter DEPTH, default 3, meaning tracked post-issue stages (1=EX … DEPTH=WB); legal range 2..7.
REQ-003 SHALL have parameter NPORT, default 2, meaning number of read ports.
REQ-004 SHALL have parameter LOAD_STAGE, default 2, meaning first stage (1-based) where load data is forwardable; legal range 1..DEPTH.
REQ-005 SHALL use derived width SELW = clog2(DEPTH+1).
REQ-006 clk  input  1  clock; the only clock; all state on rising edge.
REQ-007 rst  input  1  reset; synchronous, active-high.
REQ-008 issue_valid  input  1  an instruction is presented for issue this cycle.
REQ-009 issue_wren  input  1  the issuing instruction writes a register.
REQ-010 issue_wraddr  input  REG_AW  destination register of the issuing instruction.
REQ-011 issue_isload  input  1  the issuing instruction is a load.
REQ-012 flush  input  1  discard the issuing instruction (redirect).
REQ-013 rdreq  input  NPORT  per-port read request.
REQ-014 rdaddr  input  NPORT*REG_AW  per-port source register; port p in bits [p*REG_AW +: REG_AW].
REQ-015 stall  output  1  issue blocked this cycle (load-use).
REQ-016 fwdsel  output  NPORT*SELW  per-port source: 0 = register file, k = stage k result.
REQ-017 inflight  output  SELW  count of valid entries in stages 1..DEPTH.
REQ-018 busy  output  1  inflight != 0.

Function
REQ-019 SHALL hold a DEPTH-entry shift register; each entry holds valid, wren, wraddr, isload; entry k = stage k.
REQ-020 Every cycle, entry k SHALL move to k+1; entry DEPTH SHALL retire; older entries advance regardless of stall or flush.
REQ-021 Stage 1 SHALL load the issuing instruction when issue_valid & !stall & !flush; otherwise it SHALL load a bubble (valid=0).
REQ-022 Per port, a match SHALL be an entry with valid & wren & wraddr==rdaddr, counted only if rdreq=1 and rdaddr != 0.
REQ-023 The youngest (lowest k) match SHALL select the port's source; fwdsel = k, else 0.
REQ-024 If the selected match is a load with k < LOAD_STAGE, stall SHALL assert and that port's fwdsel SHALL be 0.
REQ-025 stall = issue_valid & !flush & (any port in REQ-024 condition); stall and fwdsel are combinational, zero latency.
REQ-026 With flush=1, stall SHALL be 0 and fwdsel is don't-care.
REQ-027 Register 0 SHALL never forward or stall, even if an in-flight entry targets it.
REQ-028 inflight SHALL be the population count of valid bits, registered state only.

Reset
REQ-029 With rst=1 at a clock edge, all entries SHALL clear to invalid, and perf counters (if present) SHALL clear to 0, overriding any simultaneous issue.
REQ-030 After reset: stall=0, fwdsel=0, inflight=0, busy=0.

Configuration
REQ-031 Macro HAZARD_SCOREBOARD_PERF_EN defined: adds outputs stall_count [31:0] and fwd_count [31:0], both saturating at 32'hFFFFFFFF.
REQ-032 stall_count SHALL increment on cycles with stall=1; fwd_count SHALL increment on accepted issues with any fwdsel != 0.
REQ-033 Macro undefined: these ports and counters SHALL be absent; all other behaviour identical.

Verification (defaults)
REQ-034 Issue wren r3, then hold rdreq0=1 rdaddr0=3 -> fwdsel0 = 1, 2, 3, 0 on successive cycles, stall=0.
REQ-035 Issue load r5, next cycle read r5 -> stall=1 one cycle, then fwdsel=2, stall=0; with PERF_EN, stall_count=1.
REQ-036 Writes to r4 in stages 1 and 2, read r4 -> fwdsel=1 (youngest wins).
REQ-037 Load to r0 in stage 1, read r0 -> stall=0, fwdsel=0.
REQ-038 Load-use hazard with flush=1 -> stall=0; next cycle stage 1 invalid, inflight decreases by the retiring entry only.
REQ-039 rst=1 with 3 valid entries and issue_valid=1 -> next cycle inflight=0, busy=0, fwdsel=0.
